m_egress_pktq: RTL and testbench
================================

Name: m_egress_pktq

Overview:
- Store-and-forward packet queue directly downstream of the match engine's egress port, in the clk_host domain.
- Captures each egress packet (vld/sop/eop/length/data/buffer) and releases it to the host consumer only once its eop beat has been written.
- The upstream stage has no backpressure, so a packet that cannot fit is dropped whole and counted.
- Presents a valid/ready stream to the host side.

Parameters:
- DATA_W, 128, width of the data beat
- LEN_W, 16, width of the length field
- BUF_W, 2, width of the buffer identifier
- DEPTH, 16, queue depth in beats; power of two, at least 2
- CNT_W, 16, width of the statistics counters

Ports:
- clk_host  in  1  host-domain clock; all logic is on its rising edge
- rst_host  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally
- in_vld_w  in  1  egress beat valid
- in_sop_w  in  1  start of packet
- in_eop_w  in  1  end of packet
- in_length_w  in  LEN_W  packet length; sampled at sop only
- in_data_w  in  DATA_W  beat data
- in_buffer_w  in  BUF_W  destination buffer; sampled at sop only
- out_vld_r  out  1  head beat valid
- out_rdy_w  in  1  consumer ready
- out_sop_r  out  1  head beat sop
- out_eop_r  out  1  head beat eop
- out_length_r  out  LEN_W  length of the head packet
- out_data_r  out  DATA_W  head beat data
- out_buffer_r  out  BUF_W  buffer of the head packet
- occ_r  out  log2(DEPTH)+1  committed beats held
- pkt_cnt_r  out  CNT_W  packets committed; saturating
- drop_cnt_r  out  CNT_W  packets dropped for lack of space; saturating
- err_cnt_r  out  CNT_W  framing errors; saturating

Behaviour:
- Reset: every output, pointer and counter goes to 0; FSM goes to IDLE.
- Reset mid-packet discards all queued and partial data.
- Storage:
  - Flop array of DEPTH entries, each holding {sop, eop, length, data, buffer}.
  - length and buffer are latched at sop and replicated into every beat of the packet.
- Pointers:
  - Three pointers of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH: wr_ptr (tentative), cm_ptr (committed), rd_ptr.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - Empty (for read) = cm_ptr == rd_ptr.
- Output:
  - First-word fall-through: out_vld_r = (cm_ptr != rd_ptr).
  - out_* fields are the entry at rd_ptr.
  - A pop occurs when out_vld_r && out_rdy_w; rd_ptr increments.
  - Output fields are held stable while out_vld_r && !out_rdy_w.
- occ_r = cm_ptr - rd_ptr, registered; it reflects state after the current cycle's commit and pop.
- Space check uses the pre-pop rd_ptr. A pop in the same cycle does not free space for that cycle's write.
- FSM states are IDLE, ACCEPT and DROP.
- IDLE:
  - vld && sop && !full: write the beat and increment wr_ptr.
    - If eop is also set: cm_ptr <= wr_ptr+1, pkt_cnt++, stay in IDLE.
    - Otherwise go to ACCEPT.
  - vld && sop && full: drop_cnt++. Go to DROP, or stay in IDLE if eop is also set.
  - vld && !sop: discard the beat, err_cnt++.
- ACCEPT:
  - vld && !sop && !full: write the beat, wr_ptr++.
    - If eop: cm_ptr <= wr_ptr+1, pkt_cnt++, go to IDLE.
  - vld && !sop && full: wr_ptr <= cm_ptr (rollback), drop_cnt++. Go to DROP, or to IDLE if eop.
  - vld && sop (sop while a packet is open):
    - Roll back the partial packet (wr_ptr <= cm_ptr) and err_cnt++.
    - Treat the beat as a new sop under IDLE rules, with the space check made against the rolled-back wr_ptr.
- DROP:
  - Beats are discarded until eop, then go to IDLE.
  - vld && sop in DROP: err_cnt++, then the beat is handled under IDLE rules.
- in_vld_w low: no state change, in any state.
- Counters saturate at all-ones.
- A packet longer than DEPTH beats is always dropped.

Test Plan:
- DEPTH=16, out_rdy_w=1: 3-beat packet (length=48, buffer=2, data 0xA,0xB,0xC).
  - out_vld_r first rises the cycle after the eop write.
  - Output is 0xA/0xB/0xC on consecutive cycles, sop on beat 1, eop on beat 3, buffer=2, length=48 on every beat; pkt_cnt_r=1.
- out_rdy_w=0: push packets of 8, 4 and 6 beats.
  - First two are committed, occ_r=12.
  - Third overflows at its 5th beat and is rolled back: drop_cnt_r=1, occ_r=12.
  - Raise out_rdy_w: exactly 12 beats are output.
- Single-beat packet (sop=eop=1) into an empty queue: committed the same cycle, out_vld_r=1 next cycle; into a full queue: drop_cnt_r++ and the FSM stays in IDLE.
- A new sop arrives while a 4-beat packet is in ACCEPT after 2 beats: err_cnt_r=1, the 2 partial beats are never output, and the new packet is output intact.
- A vld beat with sop=0 in IDLE: err_cnt_r=1, occ_r unchanged.
- Assert rst_host low in the middle of the 2nd beat of a 4-beat packet with 5 beats committed: asynchronously out_vld_r=0, occ_r=0 and all counters 0. After release, a new 2-beat packet is output correctly.

Source files
------------

// File: rtl/m_egress_pktq.sv
// Store-and-forward egress packet queue: packets become visible to the host
// only after their eop beat is written; packets that cannot fit are dropped whole.
module m_egress_pktq #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16,
  parameter int BUF_W  = 2,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_host,
  input  logic                       rst_host,
  input  logic                       in_vld_w,
  input  logic                       in_sop_w,
  input  logic                       in_eop_w,
  input  logic [LEN_W-1:0]           in_length_w,
  input  logic [DATA_W-1:0]          in_data_w,
  input  logic [BUF_W-1:0]           in_buffer_w,
  output logic                       out_vld_r,
  input  logic                       out_rdy_w,
  output logic                       out_sop_r,
  output logic                       out_eop_r,
  output logic [LEN_W-1:0]           out_length_r,
  output logic [DATA_W-1:0]          out_data_r,
  output logic [BUF_W-1:0]           out_buffer_r,
  output logic [$clog2(DEPTH):0]     occ_r,
  output logic [CNT_W-1:0]           pkt_cnt_r,
  output logic [CNT_W-1:0]           drop_cnt_r,
  output logic [CNT_W-1:0]           err_cnt_r
);

  // state  | meaning
  // IDLE   | between packets, waiting for sop
  // ACCEPT | packet open, beats written tentatively past cm_ptr
  // DROP   | packet rejected, discarding beats until eop
  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nx;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] wr_nx, cm_nx, rd_nx, base_ptr;
  logic full, we, pop, reopen;
  logic inc_pkt, inc_drop, inc_err;
  logic [LEN_W-1:0] len_q, wr_len;
  logic [BUF_W-1:0] buf_q, wr_buf;

  logic              mem_sop  [DEPTH];
  logic              mem_eop  [DEPTH];
  logic [LEN_W-1:0]  mem_len  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [BUF_W-1:0]  mem_buf  [DEPTH];

  // A sop inside an open packet is checked for space against the rolled-back pointer.
  assign reopen   = in_vld_w && in_sop_w && (state != IDLE);
  assign base_ptr = reopen ? cm_ptr : wr_ptr;
  assign full     = (base_ptr - rd_ptr) == DEPTH_P;
  assign pop      = out_vld_r && out_rdy_w;
  assign rd_nx    = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign wr_len   = in_sop_w ? in_length_w : len_q;
  assign wr_buf   = in_sop_w ? in_buffer_w : buf_q;

  always_comb begin
    state_nx = state;
    wr_nx    = wr_ptr;
    cm_nx    = cm_ptr;
    we       = 1'b0;
    inc_pkt  = 1'b0;
    inc_drop = 1'b0;
    inc_err  = 1'b0;
    if (in_vld_w) begin
      if (in_sop_w) begin
        inc_err = (state != IDLE);
        if (!full) begin
          we    = 1'b1;
          wr_nx = base_ptr + PTR_ONE;
          if (in_eop_w) begin
            cm_nx    = base_ptr + PTR_ONE;
            inc_pkt  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = ACCEPT;
          end
        end else begin
          wr_nx    = base_ptr;
          inc_drop = 1'b1;
          state_nx = in_eop_w ? IDLE : DROP;
        end
      end else begin
        case (state)
          IDLE: inc_err = 1'b1;
          ACCEPT: begin
            if (!full) begin
              we    = 1'b1;
              wr_nx = wr_ptr + PTR_ONE;
              if (in_eop_w) begin
                cm_nx    = wr_ptr + PTR_ONE;
                inc_pkt  = 1'b1;
                state_nx = IDLE;
              end
            end else begin
              wr_nx    = cm_ptr;
              inc_drop = 1'b1;
              state_nx = in_eop_w ? IDLE : DROP;
            end
          end
          DROP: if (in_eop_w) state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_host or negedge rst_host) begin
    if (!rst_host) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      rd_ptr     <= '0;
      occ_r      <= '0;
      pkt_cnt_r  <= '0;
      drop_cnt_r <= '0;
      err_cnt_r  <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_sop[i]  <= 1'b0;
        mem_eop[i]  <= 1'b0;
        mem_len[i]  <= '0;
        mem_data[i] <= '0;
        mem_buf[i]  <= '0;
      end
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_nx;
      cm_ptr <= cm_nx;
      rd_ptr <= rd_nx;
      occ_r  <= cm_nx - rd_nx;
      if (inc_pkt && pkt_cnt_r != '1)   pkt_cnt_r  <= pkt_cnt_r + CNT_ONE;
      if (inc_drop && drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + CNT_ONE;
      if (inc_err && err_cnt_r != '1)   err_cnt_r  <= err_cnt_r + CNT_ONE;
      if (we) begin
        mem_sop[base_ptr[AW-1:0]]  <= in_sop_w;
        mem_eop[base_ptr[AW-1:0]]  <= in_eop_w;
        mem_len[base_ptr[AW-1:0]]  <= wr_len;
        mem_data[base_ptr[AW-1:0]] <= in_data_w;
        mem_buf[base_ptr[AW-1:0]]  <= wr_buf;
        if (in_sop_w) begin
          len_q <= in_length_w;
          buf_q <= in_buffer_w;
        end
      end
    end
  end

  assign out_vld_r    = cm_ptr != rd_ptr;
  assign out_sop_r    = mem_sop[rd_ptr[AW-1:0]];
  assign out_eop_r    = mem_eop[rd_ptr[AW-1:0]];
  assign out_length_r = mem_len[rd_ptr[AW-1:0]];
  assign out_data_r   = mem_data[rd_ptr[AW-1:0]];
  assign out_buffer_r = mem_buf[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_m_egress_pktq.sv
// Randomized bench for m_egress_pktq: a packet-level model feeds a scoreboard
// of expected output beats; a negedge monitor pops and compares them.
module tb_m_egress_pktq;
  localparam int DATA_W = 128, LEN_W = 16, BUF_W = 2, DEPTH = 16, CNT_W = 16;
  localparam int PW = 5;

  logic              clk_host = 1'b0;
  logic              rst_host;
  logic              in_vld_w, in_sop_w, in_eop_w;
  logic [LEN_W-1:0]  in_length_w;
  logic [DATA_W-1:0] in_data_w;
  logic [BUF_W-1:0]  in_buffer_w;
  logic              out_vld_r, out_rdy_w, out_sop_r, out_eop_r;
  logic [LEN_W-1:0]  out_length_r;
  logic [DATA_W-1:0] out_data_r;
  logic [BUF_W-1:0]  out_buffer_r;
  logic [PW-1:0]     occ_r;
  logic [CNT_W-1:0]  pkt_cnt_r, drop_cnt_r, err_cnt_r;

  m_egress_pktq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_W(BUF_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_host(clk_host), .rst_host(rst_host),
    .in_vld_w(in_vld_w), .in_sop_w(in_sop_w), .in_eop_w(in_eop_w),
    .in_length_w(in_length_w), .in_data_w(in_data_w), .in_buffer_w(in_buffer_w),
    .out_vld_r(out_vld_r), .out_rdy_w(out_rdy_w), .out_sop_r(out_sop_r), .out_eop_r(out_eop_r),
    .out_length_r(out_length_r), .out_data_r(out_data_r), .out_buffer_r(out_buffer_r),
    .occ_r(occ_r), .pkt_cnt_r(pkt_cnt_r), .drop_cnt_r(drop_cnt_r), .err_cnt_r(err_cnt_r)
  );

  always #5 clk_host = ~clk_host;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic [BUF_W-1:0]  bufid;
  } beat_t;

  beat_t sb[$];
  beat_t part[$];
  int committed, popped;
  int m_pkt, m_drop, m_err;
  bit m_open, m_dropping;
  logic [LEN_W-1:0] m_len;
  logic [BUF_W-1:0] m_buf;
  int n_cmp, n_fail;
  int rdy_ctl;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x < 65535) ? x + 1 : x;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_commit();
    foreach (part[i]) sb.push_back(part[i]);
    committed += part.size();
    part.delete();
    m_open = 1'b0;
    m_pkt  = sat(m_pkt);
  endtask

  // Packet-level rules: a packet is kept only if all of it fits in DEPTH minus
  // what is committed and not yet popped (pops of this same cycle do not count).
  task automatic model_beat(input logic sop, input logic eop, input logic [LEN_W-1:0] len,
                            input logic [DATA_W-1:0] d, input logic [BUF_W-1:0] b);
    int held;
    beat_t bt;
    held = committed - popped;
    if (sop) begin
      if (m_open || m_dropping) m_err = sat(m_err);
      part.delete();
      m_open = 1'b0;
      m_dropping = 1'b0;
      if (held + 1 <= DEPTH) begin
        m_len = len;
        m_buf = b;
        bt = '{sop: 1'b1, eop: eop, len: len, data: d, bufid: b};
        part.push_back(bt);
        if (eop) model_commit();
        else m_open = 1'b1;
      end else begin
        m_drop = sat(m_drop);
        m_dropping = !eop;
      end
    end else if (m_open) begin
      if (held + part.size() + 1 <= DEPTH) begin
        bt = '{sop: 1'b0, eop: eop, len: m_len, data: d, bufid: m_buf};
        part.push_back(bt);
        if (eop) model_commit();
      end else begin
        m_drop = sat(m_drop);
        part.delete();
        m_open = 1'b0;
        m_dropping = !eop;
      end
    end else if (m_dropping) begin
      if (eop) m_dropping = 1'b0;
    end else begin
      m_err = sat(m_err);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    part.delete();
    committed = 0; popped = 0;
    m_pkt = 0; m_drop = 0; m_err = 0;
    m_open = 1'b0; m_dropping = 1'b0;
  endtask

  task automatic check_all();
    int held;
    held = committed - popped;
    chk("occ", occ_r, held);
    chk("out_vld", out_vld_r, held != 0);
    chk("pkt_cnt", pkt_cnt_r, m_pkt);
    chk("drop_cnt", drop_cnt_r, m_drop);
    chk("err_cnt", err_cnt_r, m_err);
  endtask

  task automatic step(input logic vld, input logic sop, input logic eop, input logic [LEN_W-1:0] len,
                      input logic [DATA_W-1:0] d, input logic [BUF_W-1:0] b);
    in_vld_w = vld; in_sop_w = sop; in_eop_w = eop;
    in_length_w = len; in_data_w = d; in_buffer_w = b;
    if (vld) model_beat(sop, eop, len, d, b);
    out_rdy_w = (rdy_ctl == 2) ? 1'($urandom_range(0, 1)) : (rdy_ctl == 1);
    @(posedge clk_host); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Length and buffer are driven with junk on non-sop beats; only the sop values may stick.
  task automatic send_pkt(input int n, input int gap_pct);
    logic [LEN_W-1:0] len;
    logic [BUF_W-1:0] b;
    len = LEN_W'($urandom);
    b   = BUF_W'($urandom);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      step(1'b1, i == 0, i == n - 1, (i == 0) ? len : LEN_W'($urandom), rnd_data(),
           (i == 0) ? b : BUF_W'($urandom));
    end
  endtask

  always @(negedge clk_host) begin
    if (rst_host === 1'b1 && out_vld_r === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_beat: got unexpected beat data %0h expected none", out_data_r);
      end else begin
        chk("out_beat", {out_sop_r, out_eop_r, out_length_r, out_data_r, out_buffer_r}, sb[0]);
        if (out_rdy_w) begin
          void'(sb.pop_front());
          popped++;
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; rdy_ctl = 0;
    model_reset();
    rst_host = 1'b0;
    in_vld_w = 0; in_sop_w = 0; in_eop_w = 0; in_length_w = '0; in_data_w = '0; in_buffer_w = '0;
    out_rdy_w = 0;
    #1;
    chk("rst_vld", out_vld_r, 0);
    chk("rst_occ", occ_r, 0);
    chk("rst_data", out_data_r, 0);
    chk("rst_cnts", {pkt_cnt_r, drop_cnt_r, err_cnt_r}, 0);
    repeat (2) @(negedge clk_host);
    rst_host = 1'b1;
    @(posedge clk_host); #1;

    // 3-beat packet, ready held high
    rdy_ctl = 1;
    step(1, 1, 0, 16'd48, 128'hA, 2'd2);
    step(1, 0, 0, 16'd7, 128'hB, 2'd1);
    step(1, 0, 1, 16'd9, 128'hC, 2'd0);
    chk("tp1_vld_rise", out_vld_r, 1);
    chk("tp1_data", out_data_r, 128'hA);
    idle(4);
    chk("tp1_pkt", pkt_cnt_r, 1);

    // 8 + 4 committed, 6-beat overflows on its 5th beat
    rdy_ctl = 0;
    send_pkt(8, 0);
    send_pkt(4, 0);
    chk("tp2_occ12", occ_r, 12);
    send_pkt(6, 0);
    chk("tp2_occ12_after", occ_r, 12);
    chk("tp2_drop1", drop_cnt_r, 1);
    rdy_ctl = 1;
    idle(14);
    chk("tp2_drained", sb.size(), 0);

    // single-beat into empty, then into full
    send_pkt(1, 0);
    chk("tp3_vld", out_vld_r, 1);
    idle(3);
    rdy_ctl = 0;
    send_pkt(16, 0);
    send_pkt(1, 0);
    chk("tp3_drop2", drop_cnt_r, 2);
    send_pkt(2, 0);
    rdy_ctl = 1;
    idle(20);

    // sop while a packet is open, then a stray non-sop beat in IDLE
    step(1, 1, 0, 16'd64, rnd_data(), 2'd3);
    step(1, 0, 0, 16'd0, rnd_data(), 2'd0);
    send_pkt(4, 0);
    chk("tp4_err1", err_cnt_r, 1);
    idle(6);
    step(1, 0, 0, 16'd5, rnd_data(), 2'd1);
    chk("tp5_err2", err_cnt_r, 2);
    idle(2);

    // asynchronous reset mid-packet with 5 beats committed
    rdy_ctl = 0;
    send_pkt(5, 0);
    step(1, 1, 0, 16'd4, rnd_data(), 2'd1);
    in_vld_w = 1; in_sop_w = 0; in_eop_w = 0; in_data_w = rnd_data();
    #2 rst_host = 1'b0;
    #1;
    chk("tp6_vld", out_vld_r, 0);
    chk("tp6_occ", occ_r, 0);
    chk("tp6_cnts", {pkt_cnt_r, drop_cnt_r, err_cnt_r}, 0);
    model_reset();
    @(negedge clk_host);
    in_vld_w = 0;
    #1 rst_host = 1'b1;
    @(posedge clk_host); #1;
    rdy_ctl = 1;
    send_pkt(2, 0);
    idle(4);
    chk("tp6_post", pkt_cnt_r, 1);

    // randomized traffic with random backpressure
    rdy_ctl = 2;
    for (int p = 0; p < 300; p++) begin
      int kind, n;
      kind = $urandom_range(0, 19);
      n = $urandom_range(1, 20);
      if (kind == 0) step(1, 0, $urandom_range(0, 1), LEN_W'($urandom), rnd_data(), BUF_W'($urandom));
      if (kind == 1) begin
        for (int i = 0; i < n / 2 + 1; i++)
          step(1, i == 0, 0, LEN_W'($urandom), rnd_data(), BUF_W'($urandom));
      end else begin
        send_pkt(n, 20);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    rdy_ctl = 1;
    idle(40);
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
